// File: rtl/handover_manager.sv
// Handover decision manager: hysteresis + time-to-trigger filtering of mobile
// quality reports, serving-station switch, guard period and downlink blanking.
module handover_manager #(
  parameter int SQ_W   = 8,
  parameter int DATA_W = 4,
  parameter int HYST   = 10,
  parameter int TTT    = 4,
  parameter int GUARD  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MD_DM_target,
  input  logic [SQ_W-1:0]   MD_DM_sq1,
  input  logic [SQ_W-1:0]   MD_DM_sq2,
  input  logic [SQ_W-1:0]   MD_DM_sq3,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              compare_enable,
  output logic [DATA_W-1:0] DM_MD_data,
  output logic [1:0]        serving_bs,
  output logic              handover_pulse,
  output logic              ho_busy,
  output logic [7:0]        ho_count
);

  typedef enum logic [1:0] {
    S_MONITOR,
    S_CANDIDATE,
    S_HANDOVER,
    S_GUARD
  } state_t;

  localparam logic [SQ_W:0] HYST_V     = (SQ_W+1)'(HYST);
  localparam logic [7:0]    TTT_LAST   = 8'(TTT - 1);
  localparam logic [7:0]    GUARD_LAST = 8'(GUARD - 1);

  state_t            state, state_next;
  logic [1:0]        cand;
  logic [7:0]        ttt_cnt;
  logic [7:0]        guard_cnt;
  logic [SQ_W-1:0]   sq_tgt, sq_srv;
  logic              qualify;
  logic              cand_hold;

  always_comb begin
    sq_tgt = '0;
    case (MD_DM_target)
      2'd0:    sq_tgt = MD_DM_sq1;
      2'd1:    sq_tgt = MD_DM_sq2;
      2'd2:    sq_tgt = MD_DM_sq3;
      default: sq_tgt = '0;
    endcase
  end

  always_comb begin
    sq_srv = '0;
    case (serving_bs)
      2'd0:    sq_srv = MD_DM_sq1;
      2'd1:    sq_srv = MD_DM_sq2;
      2'd2:    sq_srv = MD_DM_sq3;
      default: sq_srv = '0;
    endcase
  end

  // Margin sum is one bit wider so a near-full-scale serving quality cannot wrap.
  always_comb begin
    qualify = (MD_DM_target != 2'd3) &&
              (MD_DM_target != serving_bs) &&
              ({1'b0, sq_tgt} >= ({1'b0, sq_srv} + HYST_V));
    cand_hold = (MD_DM_target == cand) && qualify;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_MONITOR;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    compare_enable = 1'b0;
    handover_pulse = 1'b0;
    ho_busy        = 1'b0;
    case (state)
      S_MONITOR: begin
        compare_enable = 1'b1;
        if (qualify) state_next = S_CANDIDATE;
      end
      S_CANDIDATE: begin
        compare_enable = 1'b1;
        if (!cand_hold)                state_next = S_MONITOR;
        else if (ttt_cnt == TTT_LAST)  state_next = S_HANDOVER;
      end
      S_HANDOVER: begin
        handover_pulse = 1'b1;
        ho_busy        = 1'b1;
        state_next     = S_GUARD;
      end
      S_GUARD: begin
        ho_busy = 1'b1;
        if (guard_cnt == GUARD_LAST) state_next = S_MONITOR;
      end
      default: state_next = S_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand       <= '0;
      ttt_cnt    <= '0;
      guard_cnt  <= '0;
      serving_bs <= '0;
      ho_count   <= '0;
      DM_MD_data <= '0;
    end else begin
      case (state)
        S_MONITOR: begin
          if (qualify) begin
            cand    <= MD_DM_target;
            ttt_cnt <= 8'd1;
          end
          if (data_valid) DM_MD_data <= data_in;
        end
        S_CANDIDATE: begin
          if (cand_hold) ttt_cnt <= ttt_cnt + 8'd1;
          else           ttt_cnt <= '0;
          if (data_valid) DM_MD_data <= data_in;
        end
        S_HANDOVER: begin
          serving_bs <= cand;
          if (ho_count != '1) ho_count <= ho_count + 8'd1;
          guard_cnt  <= '0;
          DM_MD_data <= '0;
        end
        S_GUARD: begin
          guard_cnt  <= guard_cnt + 8'd1;
          DM_MD_data <= '0;
        end
        default: DM_MD_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_handover_manager.sv
// Directed self-checking bench for handover_manager (HYST=10, TTT=4, GUARD=8).
module tb_handover_manager;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] MD_DM_target;
  logic [7:0] MD_DM_sq1, MD_DM_sq2, MD_DM_sq3;
  logic [3:0] data_in;
  logic       data_valid;
  logic       compare_enable;
  logic [3:0] DM_MD_data;
  logic [1:0] serving_bs;
  logic       handover_pulse;
  logic       ho_busy;
  logic [7:0] ho_count;

  int vectors = 0;
  int miscompares = 0;

  handover_manager #(.SQ_W(8), .DATA_W(4), .HYST(10), .TTT(4), .GUARD(8)) dut (
    .clk(clk), .reset(reset),
    .MD_DM_target(MD_DM_target),
    .MD_DM_sq1(MD_DM_sq1), .MD_DM_sq2(MD_DM_sq2), .MD_DM_sq3(MD_DM_sq3),
    .data_in(data_in), .data_valid(data_valid),
    .compare_enable(compare_enable), .DM_MD_data(DM_MD_data),
    .serving_bs(serving_bs), .handover_pulse(handover_pulse),
    .ho_busy(ho_busy), .ho_count(ho_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    MD_DM_target = 2'd3;
    MD_DM_sq1 = '0; MD_DM_sq2 = '0; MD_DM_sq3 = '0;
    data_in = 4'h5; data_valid = 1'b0;

    // 1. Reset state
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_serving", serving_bs, 0);
    chk("rst_count", ho_count, 0);
    chk("rst_data", DM_MD_data, 0);
    chk("rst_ce", compare_enable, 1);
    chk("rst_pulse", handover_pulse, 0);
    chk("rst_busy", ho_busy, 0);

    // 2. Hysteresis boundary, 59 < 50+10, with data flowing
    MD_DM_sq1 = 8'd50; MD_DM_sq2 = 8'd59; MD_DM_target = 2'd1;
    data_in = 4'hA; data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hyst59_pulse", handover_pulse, 0);
      chk("hyst59_ce", compare_enable, 1);
    end
    chk("hyst59_serving", serving_bs, 0);
    chk("mon_data", DM_MD_data, 4'hA);

    // 60 >= 60 qualifies: pulse after the 4th qualifying edge
    MD_DM_sq2 = 8'd60;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ttt_wait_pulse", handover_pulse, 0);
      chk("ttt_wait_ce", compare_enable, 1);
    end
    step();
    chk("ho_pulse", handover_pulse, 1);
    chk("ho_busy", ho_busy, 1);
    chk("ho_ce", compare_enable, 0);
    chk("ho_serving_old", serving_bs, 0);
    step();
    chk("post_ho_pulse", handover_pulse, 0);
    chk("post_ho_serving", serving_bs, 1);
    chk("post_ho_count", ho_count, 1);

    // 4. Guard blanking: 8 GUARD cycles with data zeroed
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("guard_ce", compare_enable, 0);
      chk("guard_busy", ho_busy, 1);
      chk("guard_data", DM_MD_data, 0);
    end
    step();
    chk("mon_back_ce", compare_enable, 1);
    chk("mon_back_busy", ho_busy, 0);
    chk("mon_back_data0", DM_MD_data, 0);
    step();
    chk("mon_back_dataA", DM_MD_data, 4'hA);

    // 3. TTT abort; serving is now station 1, so its quality is sq2
    data_valid = 1'b0;
    MD_DM_sq1 = 8'd0; MD_DM_sq2 = 8'd20; MD_DM_sq3 = 8'd90; MD_DM_target = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_pre_pulse", handover_pulse, 0);
    end
    MD_DM_target = 2'd3;
    step();
    chk("abort_pulse", handover_pulse, 0);
    MD_DM_target = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_re_pulse", handover_pulse, 0);
    end
    step();
    chk("abort_ho_pulse", handover_pulse, 1);
    step();
    chk("abort_serving", serving_bs, 2);
    chk("abort_count", ho_count, 2);

    // 6. Asynchronous reset during GUARD
    step(); step();
    chk("guard2_busy", ho_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_serving", serving_bs, 0);
    chk("arst_busy", ho_busy, 0);
    chk("arst_count", ho_count, 0);
    chk("arst_ce", compare_enable, 1);
    step();
    reset = 1'b1;

    // 5. No-wrap: 255 < 250+10
    MD_DM_sq1 = 8'd250; MD_DM_sq2 = 8'd255; MD_DM_sq3 = 8'd0; MD_DM_target = 2'd1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("nowrap_pulse", handover_pulse, 0);
      chk("nowrap_ce", compare_enable, 1);
    end
    chk("nowrap_serving", serving_bs, 0);

    // Target equal to serving never triggers
    MD_DM_sq1 = 8'd255; MD_DM_sq2 = 8'd0; MD_DM_target = 2'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("self_pulse", handover_pulse, 0);
    end
    chk("self_count", ho_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
